// File: rtl/unpack_line_ctrl.sv
// unpack_line_ctrl: line/frame sequencer for a wide-word to pixel unpacker.
// At frame start it realigns the unpacker. It forces a word fetch at the start
// of every line, so each line begins on a wide-word boundary. It issues ord_en
// pixel strobes and tags the one-cycle-delayed unpacker output with
// start-of-frame, end-of-line and end-of-frame flags.
module unpack_line_ctrl #(
  parameter int ISIZE = 256,
  parameter int OSIZE = 24,
  parameter int CW    = 16
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          vs_start,
  input  logic [CW-1:0] hactive,
  input  logic [CW-1:0] vactive,
  input  logic          fifo_empty,
  input  logic          out_ready,
  output logic          ialign,
  output logic          force_rd,
  output logic          ord_en,
  output logic          ovalid,
  output logic          osof,
  output logic          oeol,
  output logic          oeof,
  output logic          busy,
  output logic [CW-1:0] line_cnt,
  output logic          cfg_err,
  output logic          frame_err
);

  // A pixel must fit inside one wide word for the unpacker to work at all.
  if (OSIZE == 0 || OSIZE > ISIZE) begin : g_bad_size
    $error("unpack_line_ctrl: OSIZE must be in 1..ISIZE");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    PRIME = 3'd2,
    WAIT  = 3'd3,
    LINE  = 3'd4,
    EOL   = 3'd5
  } state_t;

  state_t        state;
  state_t        state_n;

  // Frame geometry sampled at the accepted start; later input changes are ignored.
  logic [CW-1:0] h_size;
  logic [CW-1:0] v_size;
  logic [CW-1:0] pix_cnt;

  logic          start;
  logic          size_ok;
  logic          load;
  logic          pix_last;
  logic          line_last;
  logic          frame_last;

  // A start request seen while reset is held must not leak a cfg_err pulse.
  assign start      = vs_start & ~rst;
  assign size_ok    = (hactive != '0) && (vactive != '0);

  assign pix_last   = (pix_cnt == h_size - CW'(1));
  assign line_last  = (line_cnt == v_size - CW'(1));

  // Pixels are issued only while in LINE, and only when both the downstream
  // side and the feeding FIFO can move.
  assign ord_en     = (state == LINE) & out_ready & ~fifo_empty;

  // Final pixel of the frame issued in this cycle.
  assign frame_last = ord_en & pix_last & line_last;

  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and strobe decode; a start in any busy state overrides the normal flow.
  always_comb begin
    state_n   = state;
    ialign    = 1'b0;
    force_rd  = 1'b0;
    cfg_err   = 1'b0;
    frame_err = 1'b0;
    load      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (size_ok) begin
            load    = 1'b1;
            state_n = ALIGN;
          end else begin
            cfg_err = 1'b1;
          end
        end
      end
      ALIGN: begin
        ialign  = 1'b1;
        state_n = PRIME;
      end
      PRIME: begin
        if (!fifo_empty) begin
          force_rd = 1'b1;
          state_n  = WAIT;
        end
      end
      // The fetched word needs one cycle to land in the unpacker.
      WAIT: begin
        state_n = LINE;
      end
      LINE: begin
        if (ord_en && pix_last) begin
          state_n = line_last ? IDLE : EOL;
        end
      end
      EOL: begin
        if (!fifo_empty) begin
          force_rd = 1'b1;
          state_n  = WAIT;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Restart: the current frame is dropped. No fetch is forced because the
    // unpacker is about to be realigned anyway. Finishing the frame in the same
    // cycle is a clean hand-over, not an error.
    if (start && state != IDLE) begin
      force_rd  = 1'b0;
      frame_err = ~frame_last;
      if (size_ok) begin
        load    = 1'b1;
        state_n = ALIGN;
      end else begin
        cfg_err = 1'b1;
        state_n = IDLE;
      end
    end
  end

  // Geometry capture on an accepted start.
  always_ff @(posedge clock) begin
    if (load) begin
      h_size <= hactive;
      v_size <= vactive;
    end
  end

  // Pixel and line counters; the line index holds on the final line so it
  // keeps naming the line that was just issued.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (load) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (ord_en) begin
      if (pix_last) begin
        pix_cnt <= '0;
        if (!line_last) begin
          line_cnt <= line_cnt + CW'(1);
        end
      end else begin
        pix_cnt <= pix_cnt + CW'(1);
      end
    end
  end

  // Output valid and flags: the unpacker presents the pixel one cycle after ord_en.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      ovalid <= 1'b0;
      osof   <= 1'b0;
      oeol   <= 1'b0;
      oeof   <= 1'b0;
    end else begin
      ovalid <= ord_en;
      osof   <= ord_en & (pix_cnt == '0) & (line_cnt == '0);
      oeol   <= ord_en & pix_last;
      oeof   <= frame_last;
    end
  end

endmodule

// File: tb/tb_unpack_line_ctrl.sv
// Bench for unpack_line_ctrl: a directed vector table, hand-written corner
// sequences, and randomized frames against a frame-level reference model.
module tb_unpack_line_ctrl;

  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          vs_start = 1'b0;
  logic [CW-1:0] hactive = '0;
  logic [CW-1:0] vactive = '0;
  logic          fifo_empty = 1'b1;
  logic          out_ready = 1'b0;
  logic          ialign, force_rd, ord_en, ovalid, osof, oeol, oeof, busy;
  logic          cfg_err, frame_err;
  logic [CW-1:0] line_cnt;

  unpack_line_ctrl #(.ISIZE(256), .OSIZE(24), .CW(CW)) dut (
    .clock(clock), .rst(rst), .vs_start(vs_start), .hactive(hactive),
    .vactive(vactive), .fifo_empty(fifo_empty), .out_ready(out_ready),
    .ialign(ialign), .force_rd(force_rd), .ord_en(ord_en), .ovalid(ovalid),
    .osof(osof), .oeol(oeol), .oeof(oeof), .busy(busy), .line_cnt(line_cnt),
    .cfg_err(cfg_err), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: a frame is a sequence of h*v pixels; each issued
  // pixel pushes its expected {sof,eol,eof} tag, popped when it appears.
  bit         m_busy, m_align, m_prev_oe;
  int         m_h, m_v, m_issued, m_frd, m_since, m_ovcnt;
  logic [2:0] expq[$];

  typedef struct {
    bit         vs;
    int         h;
    int         v;
    bit         fe;
    bit         rdy;
    logic [9:0] exp;
    int         lc;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(bit vs, int h, int v, bit fe, bit rdy, logic [9:0] e, int lc);
    vec_t r;
    r.vs = vs; r.h = h; r.v = v; r.fe = fe; r.rdy = rdy; r.exp = e; r.lc = lc;
    return r;
  endfunction

  function automatic logic [9:0] outs();
    return {ialign, force_rd, ord_en, ovalid, osof, oeol, oeof, busy, cfg_err, frame_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_align = 0; m_prev_oe = 0; m_issued = 0; m_frd = 0; m_since = 100;
    expq.delete();
  endtask

  // Drive one cycle's inputs (called at a falling edge), check, update the model.
  task automatic cycle_check(input bit vs, input int h, input int v, input bit fe, input bit rdy);
    int k;
    bit ok, fin;
    vs_start = vs; hactive = CW'(h); vactive = CW'(v); fifo_empty = fe; out_ready = rdy;
    #1;
    ok  = (h != 0) && (v != 0);
    k   = m_issued;
    fin = ord_en && m_busy && (k == m_h * m_v - 1);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ialign", 32'(ialign), 32'(m_align));
    chk("ovalid", 32'(ovalid), 32'(m_prev_oe));
    if (ovalid) begin
      m_ovcnt++;
      if (expq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL ovalid_extra: ovalid with no pixel outstanding (t=%0t)", $time);
      end else begin
        chk("flags", 32'({osof, oeol, oeof}), 32'(expq.pop_front()));
      end
    end else begin
      chk("flags_idle", 32'({osof, oeol, oeof}), 32'd0);
    end
    chk("cfg_err", 32'(cfg_err), 32'(vs && !ok));
    chk("frame_err", 32'(frame_err), 32'(vs && m_busy && !fin));
    if (force_rd) chk("force_rd_gate", 32'(fifo_empty), 32'd0);
    if (ord_en) begin
      chk("ord_en_gate", 32'({out_ready, fifo_empty}), 32'd2);
      chk("ord_en_in_frame", 32'(m_busy), 32'd1);
      if (m_busy) begin
        chk("line_cnt", 32'(line_cnt), 32'(k / m_h));
        if (k % m_h == 0) begin
          chk("line_fetch", 32'(m_frd), 32'(k / m_h + 1));
          chk("land_gap", 32'(m_since >= 2), 32'd1);
        end
        expq.push_back({k == 0, (k % m_h) == m_h - 1, k == m_h * m_v - 1});
        m_issued++;
      end
    end
    if (force_rd) begin m_frd++; m_since = 1; end else if (m_since < 100) m_since++;
    if (fin) m_busy = 0;
    m_prev_oe = ord_en;
    m_align   = vs && ok;
    if (vs) begin
      if (ok) begin
        m_busy = 1; m_h = h; m_v = v; m_issued = 0; m_frd = 0;
      end else begin
        m_busy = 0;
      end
    end
  endtask

  task automatic step(input bit vs, input int h, input int v, input bit fe, input bit rdy);
    cycle_check(vs, h, v, fe, rdy);
    @(negedge clock);
  endtask

  function automatic bit pct(int p);
    return $urandom_range(99) < p;
  endfunction

  // mode 0: FIFO full and sink ready; 1: sink toggles; 2: random both.
  // Size inputs wander every cycle to show they are not re-sampled.
  task automatic run(input int mode, input int stop_at);
    int  n;
    bit  tog;
    n = 0; tog = 1;
    while (m_busy && (stop_at < 0 || m_issued < stop_at)) begin
      if (n == 600) begin
        vectors++; miscompares++;
        $display("FAIL timeout: frame still busy after %0d cycles", n);
        break;
      end
      case (mode)
        0: step(0, $urandom_range(9), $urandom_range(9), 0, 1);
        1: step(0, $urandom_range(9), $urandom_range(9), 0, tog);
        default: step(0, $urandom_range(9), $urandom_range(9), pct(25), pct(70));
      endcase
      tog = ~tog;
      n++;
    end
  endtask

  task automatic flush();
    repeat (2) step(0, $urandom_range(9), $urandom_range(9), 0, 1);
  endtask

  initial begin
    int h, v;
    // Basic 4x2 frame starting on the first cycle after reset, restart on the
    // final pixel, rejected restart mid-prime, then rejected starts in IDLE.
    // exp = {ialign,force_rd,ord_en,ovalid,osof,oeol,oeof,busy,cfg_err,frame_err}
    tbl[0]  = mk(1, 4, 2, 0, 1, 10'b0000000000, 0);
    tbl[1]  = mk(0, 9, 0, 0, 1, 10'b1000000100, 0);
    tbl[2]  = mk(0, 9, 0, 0, 1, 10'b0100000100, 0);
    tbl[3]  = mk(0, 9, 0, 0, 1, 10'b0000000100, 0);
    tbl[4]  = mk(0, 9, 0, 0, 1, 10'b0010000100, 0);
    tbl[5]  = mk(0, 9, 0, 0, 1, 10'b0011100100, 0);
    tbl[6]  = mk(0, 9, 0, 0, 1, 10'b0011000100, 0);
    tbl[7]  = mk(0, 9, 0, 0, 1, 10'b0011000100, 0);
    tbl[8]  = mk(0, 9, 0, 0, 1, 10'b0101010100, 1);
    tbl[9]  = mk(0, 9, 0, 0, 1, 10'b0000000100, 1);
    tbl[10] = mk(0, 9, 0, 0, 1, 10'b0010000100, 1);
    tbl[11] = mk(0, 9, 0, 0, 1, 10'b0011000100, 1);
    tbl[12] = mk(0, 9, 0, 0, 1, 10'b0011000100, 1);
    tbl[13] = mk(1, 4, 2, 0, 1, 10'b0011000100, 1);
    tbl[14] = mk(0, 9, 0, 0, 1, 10'b1001011100, 0);
    tbl[15] = mk(1, 0, 2, 1, 1, 10'b0000000111, 0);
    tbl[16] = mk(0, 9, 0, 0, 1, 10'b0000000000, 0);
    tbl[17] = mk(1, 0, 3, 0, 1, 10'b0000000010, 0);
    tbl[18] = mk(1, 3, 0, 0, 1, 10'b0000000010, 0);
    tbl[19] = mk(0, 9, 0, 0, 1, 10'b0000000000, 0);

    model_reset();
    m_ovcnt = 0;
    // Reset holds everything quiet even with start requests present.
    vs_start = 1; hactive = 0; vactive = 0; fifo_empty = 0; out_ready = 1;
    @(negedge clock);
    #1;
    chk("reset_outs_badcfg", 32'(outs()), 32'd0);
    chk("reset_line_cnt", 32'(line_cnt), 32'd0);
    hactive = 4; vactive = 2;
    #1;
    chk("reset_outs_goodcfg", 32'(outs()), 32'd0);
    @(negedge clock);
    rst = 0;

    for (int i = 0; i < 20; i++) begin
      cycle_check(tbl[i].vs, tbl[i].h, tbl[i].v, tbl[i].fe, tbl[i].rdy);
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_line", i), 32'(line_cnt), 32'(tbl[i].lc));
      @(negedge clock);
    end

    // Stall: sink toggles every cycle.
    m_ovcnt = 0;
    step(1, 4, 2, 0, 1);
    run(1, -1);
    flush();
    chk("stall_pixels", 32'(m_ovcnt), 32'd8);

    // Starvation: FIFO empty for 5 cycles in PRIME and 3 cycles mid-line.
    m_ovcnt = 0;
    step(1, 4, 2, 0, 1);
    step(0, 9, 9, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cycle_check(0, 9, 9, 1, 1);
      chk("prime_hold", 32'({force_rd, ord_en}), 32'd0);
      @(negedge clock);
    end
    run(0, 2);
    for (int i = 0; i < 3; i++) begin
      cycle_check(0, 9, 9, 1, 1);
      chk("starve_hold", 32'({force_rd, ord_en}), 32'd0);
      @(negedge clock);
    end
    run(0, -1);
    flush();
    chk("starve_pixels", 32'(m_ovcnt), 32'd8);

    // Restart on the 3rd pixel of a 6x1 frame.
    m_ovcnt = 0;
    step(1, 6, 1, 0, 1);
    run(0, 2);
    cycle_check(1, 6, 1, 0, 1);
    chk("restart_frame_err", 32'(frame_err), 32'd1);
    @(negedge clock);
    cycle_check(0, 9, 9, 0, 1);
    chk("restart_ialign", 32'(ialign), 32'd1);
    @(negedge clock);
    run(0, -1);
    flush();
    chk("restart_pixels", 32'(m_ovcnt), 32'd9);

    // Reset mid-line, then a clean frame.
    step(1, 4, 2, 0, 1);
    run(0, 3);
    rst = 1; vs_start = 0; fifo_empty = 0; out_ready = 1;
    #1;
    chk("midline_rst_outs", 32'(outs()), 32'd0);
    chk("midline_rst_line", 32'(line_cnt), 32'd0);
    @(negedge clock);
    #1;
    chk("midline_rst_hold", 32'(outs()), 32'd0);
    @(negedge clock);
    rst = 0;
    model_reset();
    m_ovcnt = 0;
    step(1, 4, 2, 0, 1);
    run(0, -1);
    flush();
    chk("post_rst_pixels", 32'(m_ovcnt), 32'd8);

    // Random frames with occasional restarts (valid or invalid sizes).
    for (int f = 0; f < 40; f++) begin
      int n;
      h = $urandom_range(6, 1);
      v = $urandom_range(4, 1);
      step(1, h, v, pct(25), pct(70));
      n = 0;
      while (m_busy && n < 600) begin
        if (pct(2)) step(1, $urandom_range(6), $urandom_range(4), pct(25), pct(70));
        else step(0, $urandom_range(9), $urandom_range(9), pct(25), pct(70));
        n++;
      end
      if (m_busy) begin
        vectors++; miscompares++;
        $display("FAIL rand_timeout: frame %0d still busy", f);
      end
      flush();
      chk("rand_drained", 32'(expq.size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
